// File: rtl/ram_port_ctrl.sv
// Access controller for a single-port RAM: converts valid/ready requests and a
// fill command into setup/pulse/hold write cycles and two-cycle read cycles.
module ram_port_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  wr_done,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_base,
  output logic                  busy,
  output logic                  ram_we,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_EN,
    RD_CAP
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic                    fill_active;
  logic [ADDR_WIDTH:0]     fill_cnt;
  logic [DATA_WIDTH-1:0]   fill_base_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    drive_q;
  logic                    fill_last;

  assign req_ready = (state == IDLE) && !reset;
  assign fill_last = (fill_cnt == (ADDR_WIDTH + 1)'(DEPTH - 1));
  assign ram_data  = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (fill_start)     next_state = WR_SETUP;
        else if (req_valid) next_state = req_wr ? WR_SETUP : RD_EN;
      end
      WR_SETUP: next_state = WR_PULSE;
      WR_PULSE: next_state = WR_HOLD;
      WR_HOLD:  next_state = (fill_active && !fill_last) ? WR_SETUP : IDLE;
      RD_EN:    next_state = RD_CAP;
      RD_CAP:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // RAM-facing outputs are decoded from next_state so they are flops that
  // line up exactly with the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_we      <= 1'b0;
      ram_en      <= 1'b0;
      ram_addr    <= '0;
      drive_q     <= 1'b0;
      wdata_q     <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      wr_done     <= 1'b0;
      busy        <= 1'b0;
      fill_active <= 1'b0;
      fill_cnt    <= '0;
      fill_base_q <= '0;
    end else begin
      ram_we   <= (next_state == WR_PULSE);
      ram_en   <= (next_state == RD_EN) || (next_state == RD_CAP);
      drive_q  <= (next_state == WR_SETUP) || (next_state == WR_PULSE) ||
                  (next_state == WR_HOLD);
      busy     <= (next_state != IDLE);
      rd_valid <= (state == RD_CAP);
      wr_done  <= (state == WR_HOLD) && (next_state == IDLE);

      if (state == RD_CAP) rd_data <= ram_data;

      if (state == IDLE) begin
        if (fill_start) begin
          fill_active <= 1'b1;
          fill_cnt    <= '0;
          fill_base_q <= fill_base;
          ram_addr    <= '0;
          wdata_q     <= fill_base;
        end else if (req_valid) begin
          ram_addr <= req_addr;
          wdata_q  <= req_wdata;
        end
      end else if (state == WR_HOLD) begin
        // Step straight to the next fill address; the last one ends the fill.
        if (fill_active && !fill_last) begin
          fill_cnt <= fill_cnt + 1'b1;
          ram_addr <= ADDR_WIDTH'(fill_cnt + 1'b1);
          wdata_q  <= fill_base_q + DATA_WIDTH'(fill_cnt + 1'b1);
        end else begin
          fill_active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Scoreboard bench for ram_port_ctrl with a behavioural 16x8 RAM on the bus.
module tb_ram_port_ctrl;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_done;
  logic       fill_start;
  logic [7:0] fill_base;
  logic       busy;
  logic       ram_we;
  logic       ram_en;
  logic [3:0] ram_addr;
  wire  [7:0] ram_data;

  ram_port_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_done    (wr_done),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .busy       (busy),
    .ram_we     (ram_we),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data)
  );

  // RAM model: writes on we, drives the bus while enabled and not writing.
  logic [7:0] mem [16] = '{default: 8'h00};
  assign ram_data = (ram_en && !ram_we) ? mem[ram_addr] : 8'bz;
  always @(posedge clock) if (ram_we) mem[ram_addr] <= ram_data;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef enum {K_WR, K_RD, K_FILL} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] shadow [16] = '{default: 8'h00};

  // Output monitor: bus rules every cycle, completions against the scoreboard.
  always @(negedge clock) begin
    check("we_en_exclusive", 32'(ram_we & ram_en), 32'd0);
    if (ram_en === 1'b1) check("rd_bus_clean", 32'(ram_data), 32'(mem[ram_addr]));
    if (busy === 1'b0) check("idle_bus_z", 32'(ram_data === 8'bz), 32'd1);
    if (rd_valid === 1'b1 || wr_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, rd_valid, wr_done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_is_rd", 32'(rd_valid), 32'(mon_e.kind == K_RD));
        check("pulse_is_wr", 32'(wr_done), 32'(mon_e.kind != K_RD));
        if (mon_e.kind == K_RD) check("rd_data", 32'(rd_data), 32'(mon_e.data));
        check("latency", cyc, mon_e.due);
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      check("late_pulse", cyc, exp_q[0].due);
      void'(exp_q.pop_front());
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b1;
    for (int i = 0; i < 100 && req_ready !== 1'b1; i++) @(negedge clock);
    if (req_ready !== 1'b1) begin
      check("ready_timeout", 32'd0, 32'd1);
      ok = 1'b0;
    end
  endtask

  // Present a request at a negedge and hold it until the accepting edge.
  task automatic do_req(input bit wr, input logic [3:0] a, input logic [7:0] d,
                        input bit d_is_exp = 1'b0);
    bit   ok;
    exp_t e;
    @(negedge clock);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    wait_ready(ok);
    if (!ok) return;
    if (wr) begin
      shadow[a] = d;
      e = '{kind: K_WR, data: 8'h00, due: cyc + 1 + 3};
    end else begin
      e = '{kind: K_RD, data: d_is_exp ? d : shadow[a], due: cyc + 1 + 2};
    end
    exp_q.push_back(e);
    @(posedge clock);
  endtask

  task automatic do_fill(input logic [7:0] b);
    bit ok;
    @(negedge clock);
    fill_start = 1'b1;
    fill_base  = b;
    wait_ready(ok);
    if (!ok) return;
    for (int a = 0; a < 16; a++) shadow[a] = b + 8'(a);
    exp_q.push_back('{kind: K_FILL, data: 8'h00, due: cyc + 1 + 48});
    @(posedge clock);
    @(negedge clock);
    fill_start = 1'b0;
  endtask

  task automatic quiet();
    @(negedge clock);
    req_valid  = 1'b0;
    fill_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    int facc;
    int racc;

    reset      = 1'b1;
    req_valid  = 1'b1;
    req_wr     = 1'b0;
    req_addr   = 4'h0;
    req_wdata  = 8'h00;
    fill_start = 1'b0;
    fill_base  = 8'h00;

    // Reset held two cycles with a pending request.
    repeat (2) begin
      @(negedge clock);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_outputs", {26'd0, ram_we, ram_en, rd_valid, wr_done, busy, 1'b0}, 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_bus_z", 32'(ram_data === 8'bz), 32'd1);
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Write 0xA5 to 5: one-cycle we with address/data stable around it.
    do_req(1'b1, 4'h5, 8'hA5);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      check("wr_we_shape", 32'(ram_we), 32'(k == 2));
      check("wr_addr_stable", 32'(ram_addr), 32'h5);
      check("wr_data_stable", 32'(ram_data), 32'hA5);
      check("wr_en_low", 32'(ram_en), 32'd0);
    end
    do_req(1'b0, 4'h5, 8'hA5, 1'b1);
    quiet();

    // Reset asserted during WR_PULSE aborts the write without wr_done.
    @(negedge clock);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 4'h9;
    req_wdata = 8'h77;
    wait_ready(ok);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check("mid_pulse_we", 32'(ram_we), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_we", 32'(ram_we), 32'd0);
    check("abort_bus_z", 32'(ram_data === 8'bz), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_done", 32'(wr_done), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_idle_ready", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clock);
    do_req(1'b1, 4'hA, 8'h3C);
    do_req(1'b0, 4'hA, 8'h3C, 1'b1);
    quiet();

    // Fill with wrap of the data pattern.
    do_fill(8'hF8);
    do_req(1'b0, 4'h0, 8'hF8, 1'b1);
    do_req(1'b0, 4'h7, 8'hFF, 1'b1);
    do_req(1'b0, 4'h8, 8'h00, 1'b1);
    do_req(1'b0, 4'hF, 8'h07, 1'b1);
    quiet();

    // fill_start beats a simultaneous read; the read follows the fill.
    @(negedge clock);
    fill_start = 1'b1;
    fill_base  = 8'h21;
    req_valid  = 1'b1;
    req_wr     = 1'b0;
    req_addr   = 4'h3;
    wait_ready(ok);
    facc = cyc + 1;
    for (int a = 0; a < 16; a++) shadow[a] = 8'h21 + 8'(a);
    exp_q.push_back('{kind: K_FILL, data: 8'h00, due: facc + 48});
    @(posedge clock);
    @(negedge clock);
    fill_start = 1'b0;
    wait_ready(ok);
    racc = cyc + 1;
    check("prio_read_accept", racc, facc + 49);
    exp_q.push_back('{kind: K_RD, data: 8'h24, due: racc + 2});
    @(posedge clock);
    quiet();

    // Random mix, mostly back-to-back, with occasional idle gaps.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        quiet();
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    quiet();

    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clock);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
